// File: rtl/ftdi_rx_ctrl.sv
// ftdi_rx_ctrl: paces FTDI FIFO byte reads (one activate pulse per byte),
// buffers each byte in a 2**AW circular buffer and streams it out.
// Ports: clk, rst (async, active low); iFIFO_RXF_n, oACT_RD_n, iRUN_RD_n,
// iDONE_RD_n, iRD_DATA (reader side); oRX_DATA, oRX_VALID, iRX_READY,
// oRX_LEVEL (consumer side); oERR (timeout pulse).
// Optional: define FTDI_RX_TIMEOUT_EN to abort a WAIT with no done strobe.
module ftdi_rx_ctrl #(
  parameter int AW          = 4,
  parameter int GAP_CYC     = 2,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        iFIFO_RXF_n,
  output logic        oACT_RD_n,
  input  logic        iRUN_RD_n,
  input  logic        iDONE_RD_n,
  input  logic [7:0]  iRD_DATA,
  output logic [7:0]  oRX_DATA,
  output logic        oRX_VALID,
  input  logic        iRX_READY,
  output logic [AW:0] oRX_LEVEL,
  output logic        oERR
);

  localparam int DEPTH = 1 << AW;
  // One counter serves GAP and the WAIT timeout; they never overlap.
  localparam int CMAX = (TIMEOUT_CYC > GAP_CYC) ? TIMEOUT_CYC : GAP_CYC;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_GAP  = 2'd3;

  localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LVL_RSV  = (AW+1)'(DEPTH - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYC - 1);

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW-1:0] rptr_nxt;
  logic [AW:0]   level;
  logic          done;
  logic          start;
  logic          wr;
  logic          pop;

  assign done  = ~iDONE_RD_n;
  // One slot stays free for the byte already in flight.
  assign start = ~iFIFO_RXF_n & iRUN_RD_n & (level < LVL_RSV);
  assign wr    = (state == S_WAIT) & done & (level != LVL_FULL);
  assign pop   = oRX_VALID & iRX_READY;

  assign rptr_nxt  = rptr + {{(AW-1){1'b0}}, pop};
  assign oRX_LEVEL = level;

`ifdef FTDI_RX_TIMEOUT_EN
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYC - 1);
  logic err_q;
  assign oERR = err_q;
`else
  assign oERR = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      oACT_RD_n <= 1'b1;
`ifdef FTDI_RX_TIMEOUT_EN
      err_q     <= 1'b0;
`endif
    end else begin
      oACT_RD_n <= 1'b1;
`ifdef FTDI_RX_TIMEOUT_EN
      err_q     <= 1'b0;
`endif
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_REQ;
            oACT_RD_n <= 1'b0;
          end
        end
        S_REQ: begin
          state <= S_WAIT;
          cnt   <= '0;
        end
        S_WAIT: begin
          if (done) begin
            state <= S_GAP;
            cnt   <= '0;
          end
`ifdef FTDI_RX_TIMEOUT_EN
          else if (cnt == TO_LAST) begin
            state <= S_GAP;
            cnt   <= '0;
            err_q <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
`endif
        end
        S_GAP: begin
          if (cnt == GAP_LAST) state <= S_IDLE;
          else cnt <= cnt + CW'(1);
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= iRD_DATA;
  end

  // Head registers read the pre-write array, so a fresh byte shows up
  // one edge after it is stored; level - pop counts only older bytes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr      <= '0;
      rptr      <= '0;
      level     <= '0;
      oRX_DATA  <= 8'h00;
      oRX_VALID <= 1'b0;
    end else begin
      if (wr) wptr <= wptr + AW'(1);
      rptr      <= rptr_nxt;
      level     <= level + {{AW{1'b0}}, wr} - {{AW{1'b0}}, pop};
      oRX_DATA  <= mem[rptr_nxt];
      oRX_VALID <= (level != {{AW{1'b0}}, pop});
    end
  end

endmodule

// File: tb/tb_ftdi_rx_ctrl.sv
// tb_ftdi_rx_ctrl: scoreboard bench for ftdi_rx_ctrl with a reader model
// (3-cycle done latency) and a consumer whose ready pattern is selectable.
module tb_ftdi_rx_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rxf_n = 1'b1;
  logic       act_n;
  logic       run_n = 1'b1;
  logic       done_n = 1'b1;
  logic [7:0] rd_data = 8'h00;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic [4:0] rx_level;
  logic       err;

  int errors = 0;
  int checks = 0;

  logic [7:0] sb [$];
  logic [7:0] rd_next = 8'h00;
  bit         rd_en = 1'b0;
  int         rd_cnt = 0;
  int         act_cnt = 0;
  int         pops = 0;
  int         ready_mode = 0;

  always #5 clk = ~clk;

  ftdi_rx_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .iFIFO_RXF_n(rxf_n),
    .oACT_RD_n  (act_n),
    .iRUN_RD_n  (run_n),
    .iDONE_RD_n (done_n),
    .iRD_DATA   (rd_data),
    .oRX_DATA   (rx_data),
    .oRX_VALID  (rx_valid),
    .iRX_READY  (rx_ready),
    .oRX_LEVEL  (rx_level),
    .oERR       (err)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reader model: done pulse 3 cycles after the activate low cycle.
  initial forever begin
    @(negedge clk);
    if (rd_en && !act_n) begin
      run_n = 1'b0;
      repeat (3) @(negedge clk);
      done_n  = 1'b0;
      rd_data = rd_next;
      sb.push_back(rd_next);
      rd_next = rd_next + 8'h01;
      rd_cnt++;
      @(negedge clk);
      done_n = 1'b1;
      run_n  = 1'b1;
    end
  end

  // Consumer: 0 off, 1 on, 2 toggle, 3 single cycle.
  initial forever begin
    logic [31:0] e;
    @(negedge clk);
    if (!act_n) act_cnt++;
    case (ready_mode)
      1: rx_ready = 1'b1;
      2: rx_ready = ~rx_ready;
      3: begin rx_ready = 1'b1; ready_mode = 0; end
      default: rx_ready = 1'b0;
    endcase
    if (rx_valid && rx_ready) begin
      if (sb.size() != 0) e = {24'h0, sb.pop_front()};
      else e = 32'hDEAD;
      chk("pop_data", {24'h0, rx_data}, e);
      pops++;
    end
  end

  task automatic wait_rd(input int n);
    int i = 0;
    while (rd_cnt < n && i < 400) begin
      @(posedge clk);
      i++;
    end
    chk("rd_wait", rd_cnt >= n, 1);
  endtask

  task automatic drain();
    int i = 0;
    while ((sb.size() != 0 || rx_level != 0) && i < 600) begin
      @(negedge clk);
      i++;
    end
    @(negedge clk);
    @(negedge clk);
    chk("drain_lvl", rx_level, 0);
    chk("drain_sb", sb.size(), 0);
    chk("drain_vld", rx_valid, 0);
  endtask

  task automatic wait_act();
    int i = 0;
    while (act_n && i < 50) begin
      @(negedge clk);
      i++;
    end
    chk("act_seen", act_n, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base_rd;
    int base_act;
    int base_pop;
    int n;

    // Reset held with RXF low: nothing may start.
    rxf_n   = 1'b0;
    rd_en   = 1'b1;
    rd_next = 8'hA5;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_act", act_n, 1);
      chk("rst_vld", rx_valid, 0);
      chk("rst_lvl", rx_level, 0);
    end
    rst = 1'b1;

    // Single byte A5.
    wait_rd(1);
    @(negedge clk);
    chk("sb_lvl1", rx_level, 1);
    chk("sb_vld_lag", rx_valid, 0);
    @(negedge clk);
    chk("sb_vld", rx_valid, 1);
    chk("sb_data", rx_data, 8'hA5);
    @(posedge clk);
    chk("sb_one_act", act_cnt, 1);
    @(negedge clk);
    chk("sb_gap_act", act_n, 1);
    @(negedge clk);
    chk("sb_next_act", act_n, 0);
    rxf_n = 1'b1;
    wait_rd(2);
    repeat (3) @(negedge clk);
    @(posedge clk);
    ready_mode = 1;
    drain();

    // Fill to 15 and throttle.
    @(posedge clk);
    ready_mode = 0;
    base_rd  = rd_cnt;
    base_act = act_cnt;
    @(negedge clk);
    rd_next = 8'h00;
    rxf_n   = 1'b0;
    wait_rd(base_rd + 15);
    repeat (20) @(negedge clk);
    chk("fill_lvl", rx_level, 15);
    chk("fill_vld", rx_valid, 1);
    chk("fill_head", rx_data, 8'h00);
    @(posedge clk);
    chk("fill_acts", act_cnt, base_act + 15);
    ready_mode = 3;
    @(negedge clk);
    @(negedge clk);
    chk("thr_lvl14", rx_level, 14);
    wait_rd(base_rd + 16);
    repeat (20) @(negedge clk);
    chk("thr_lvl15", rx_level, 15);
    @(posedge clk);
    chk("thr_acts", act_cnt, base_act + 16);
    @(negedge clk);
    rxf_n = 1'b1;
    @(posedge clk);
    ready_mode = 1;
    drain();

    // 40 bytes with toggling ready; pointers wrap.
    @(posedge clk);
    ready_mode = 2;
    base_rd  = rd_cnt;
    base_pop = pops;
    @(negedge clk);
    rd_next = 8'h10;
    rxf_n   = 1'b0;
    wait_rd(base_rd + 40);
    @(negedge clk);
    rxf_n = 1'b1;
    drain();
    @(posedge clk);
    chk("wrap_pops", pops - base_pop, 40);

    // Reset during WAIT, then a stale done with FF.
    ready_mode = 0;
    rd_en = 1'b0;
    @(negedge clk);
    rxf_n = 1'b0;
    wait_act();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rxf_n = 1'b1;
    @(negedge clk);
    chk("mr_act", act_n, 1);
    chk("mr_lvl", rx_level, 0);
    rst = 1'b1;
    @(negedge clk);
    done_n  = 1'b0;
    rd_data = 8'hFF;
    @(negedge clk);
    done_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("mr_stale_lvl", rx_level, 0);
    chk("mr_stale_vld", rx_valid, 0);
    @(posedge clk);
    rd_en = 1'b1;
    n = rd_cnt + 1;
    @(negedge clk);
    rd_next = 8'h42;
    rxf_n   = 1'b0;
    wait_rd(n);
    @(negedge clk);
    rxf_n = 1'b1;
    @(posedge clk);
    ready_mode = 1;
    drain();

`ifdef FTDI_RX_TIMEOUT_EN
    // Reader never answers: WAIT times out.
    @(posedge clk);
    ready_mode = 0;
    rd_en = 1'b0;
    @(negedge clk);
    rxf_n = 1'b0;
    wait_act();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!err && n < 100);
    chk("to_lat", n, 65);
    chk("to_lvl", rx_level, 0);
    @(negedge clk);
    chk("to_pulse", err, 0);
    @(negedge clk);
    @(negedge clk);
    chk("to_react", act_n, 0);
    rxf_n = 1'b1;
`endif

    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
